// File: rtl/maxnet_ctrl_param.sv
// MaxNet sequencing controller: loads N activations over valid/ready, then iterates
// Init -> (Mul -> Sum -> Update)* until the datapath signals a single winner or the pass cap hits.
module maxnet_ctrl_param #(
    parameter int N        = 4,
    parameter int ADDR_W   = 2,
    parameter int MUL_LAT  = 1,
    parameter int MAX_ITER = 16,
    parameter int ITER_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              finish,
    output logic              ld_memory,
    output logic [ADDR_W-1:0] ld_addr,
    output logic              ld_reg,
    output logic              sel,
    output logic              mul_en,
    output logic              done,
    output logic              busy,
    output logic [ITER_W-1:0] iter_count,
    output logic              timeout
);

    localparam int MUL_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    localparam logic [ADDR_W-1:0] LD_LAST  = ADDR_W'(N - 1);
    localparam logic [MUL_W-1:0]  MUL_LAST = MUL_W'(MUL_LAT - 1);
    localparam logic [ITER_W-1:0] ITER_CAP = ITER_W'(MAX_ITER);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        INIT   = 3'd2,
        MUL    = 3'd3,
        SUM    = 3'd4,
        UPDATE = 3'd5
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ld_cnt_reg, ld_cnt_next;
    logic [MUL_W-1:0]  mul_cnt_reg, mul_cnt_next;
    logic [ITER_W-1:0] iter_reg, iter_next;
    logic              timeout_reg, timeout_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            ld_cnt_reg  <= '0;
            mul_cnt_reg <= '0;
            iter_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ld_cnt_reg  <= ld_cnt_next;
            mul_cnt_reg <= mul_cnt_next;
            iter_reg    <= iter_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        ld_cnt_next  = ld_cnt_reg;
        mul_cnt_next = mul_cnt_reg;
        iter_next    = iter_reg;
        timeout_next = timeout_reg;
        in_ready     = 1'b0;
        ld_memory    = 1'b0;
        ld_addr      = '0;
        ld_reg       = 1'b0;
        sel          = 1'b0;
        mul_en       = 1'b0;
        done         = 1'b0;

        case (state_reg)
            IDLE: begin
                done = 1'b1;
                if (start) begin
                    state_next   = LOAD;
                    ld_cnt_next  = '0;
                    iter_next    = '0;
                    timeout_next = 1'b0;
                end
            end
            LOAD: begin
                in_ready  = 1'b1;
                ld_addr   = ld_cnt_reg;
                ld_memory = in_valid;
                if (in_valid) begin
                    ld_cnt_next = ld_cnt_reg + ADDR_W'(1);
                    if (ld_cnt_reg == LD_LAST) begin
                        state_next = INIT;
                    end
                end
            end
            INIT: begin
                ld_reg       = 1'b1;
                sel          = 1'b1;
                mul_cnt_next = '0;
                state_next   = MUL;
            end
            MUL: begin
                mul_en       = 1'b1;
                mul_cnt_next = mul_cnt_reg + MUL_W'(1);
                if (mul_cnt_reg == MUL_LAST) begin
                    state_next = SUM;
                end
            end
            SUM: begin
                // A winner takes precedence over the cap on the same pass.
                if (finish) begin
                    state_next   = IDLE;
                    timeout_next = 1'b0;
                end else if (iter_reg == ITER_CAP) begin
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                end else begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                ld_reg       = 1'b1;
                iter_next    = iter_reg + ITER_W'(1);
                mul_cnt_next = '0;
                state_next   = MUL;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort cancels this cycle's writes and freezes run bookkeeping.
        if (abort && (state_reg != IDLE)) begin
            state_next   = IDLE;
            ld_memory    = 1'b0;
            ld_reg       = 1'b0;
            ld_cnt_next  = ld_cnt_reg;
            mul_cnt_next = mul_cnt_reg;
            iter_next    = iter_reg;
            timeout_next = timeout_reg;
        end
    end

    assign busy       = ~done;
    assign iter_count = iter_reg;
    assign timeout    = timeout_reg;

endmodule

// File: tb/tb_maxnet_ctrl_param.sv
// Directed bench: cycle table on the default controller, plus hand sequences on a
// MUL_LAT=3 / MAX_ITER=2 instance for multiplier dwell, timeout and abort.
module tb_maxnet_ctrl_param;

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b, abort, in_valid, finish;

    logic       a_in_ready, a_ld_memory, a_ld_reg, a_sel, a_mul_en, a_done, a_busy, a_timeout;
    logic [1:0] a_ld_addr;
    logic [4:0] a_iter;
    logic       b_in_ready, b_ld_memory, b_ld_reg, b_sel, b_mul_en, b_done, b_busy, b_timeout;
    logic [1:0] b_ld_addr;
    logic [4:0] b_iter;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    maxnet_ctrl_param #(.N(4), .ADDR_W(2), .MUL_LAT(1), .MAX_ITER(16), .ITER_W(5)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort),
        .in_valid(in_valid), .in_ready(a_in_ready), .finish(finish),
        .ld_memory(a_ld_memory), .ld_addr(a_ld_addr), .ld_reg(a_ld_reg), .sel(a_sel),
        .mul_en(a_mul_en), .done(a_done), .busy(a_busy),
        .iter_count(a_iter), .timeout(a_timeout)
    );

    maxnet_ctrl_param #(.N(4), .ADDR_W(2), .MUL_LAT(3), .MAX_ITER(2), .ITER_W(5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort),
        .in_valid(in_valid), .in_ready(b_in_ready), .finish(finish),
        .ld_memory(b_ld_memory), .ld_addr(b_ld_addr), .ld_reg(b_ld_reg), .sel(b_sel),
        .mul_en(b_mul_en), .done(b_done), .busy(b_busy),
        .iter_count(b_iter), .timeout(b_timeout)
    );

    // {done, busy, in_ready, ld_memory, ld_addr, ld_reg, sel, mul_en, timeout, iter_count}
    logic [14:0] a_out, b_out;
    assign a_out = {a_done, a_busy, a_in_ready, a_ld_memory, a_ld_addr, a_ld_reg, a_sel,
                    a_mul_en, a_timeout, a_iter};
    assign b_out = {b_done, b_busy, b_in_ready, b_ld_memory, b_ld_addr, b_ld_reg, b_sel,
                    b_mul_en, b_timeout, b_iter};

    typedef struct {
        logic       start, abort, in_valid, finish;
        logic       done, rdy, ldm;
        logic [1:0] addr;
        logic       ldr, sel, mul;
        logic [4:0] iter;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, ab, v, f,
                       input logic dn, rdy, ldm, input logic [1:0] addr,
                       input logic ldr, sl, mul, input logic [4:0] iter, input logic to);
        vec_t r;
        r.start = st; r.abort = ab; r.in_valid = v; r.finish = f;
        r.done = dn; r.rdy = rdy; r.ldm = ldm; r.addr = addr;
        r.ldr = ldr; r.sel = sl; r.mul = mul; r.iter = iter; r.to = to;
        vecs.push_back(r);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    initial begin
        int cyc, run, runs, bad_run, upd;
        logic [14:0] exp;

        // Nominal run: start/finish noise in INIT and MUL must be ignored.
        //  st ab v  f   dn rdy ldm addr ldr sel mul iter to
        add(1, 0, 0, 0,  1, 0, 0, 2'd0, 0, 0, 0, 5'd0, 0);
        add(0, 0, 1, 0,  0, 1, 1, 2'd0, 0, 0, 0, 5'd0, 0);
        add(0, 0, 1, 0,  0, 1, 1, 2'd1, 0, 0, 0, 5'd0, 0);
        add(0, 0, 1, 0,  0, 1, 1, 2'd2, 0, 0, 0, 5'd0, 0);
        add(0, 0, 1, 0,  0, 1, 1, 2'd3, 0, 0, 0, 5'd0, 0);
        add(0, 0, 1, 1,  0, 0, 0, 2'd0, 1, 1, 0, 5'd0, 0);
        add(1, 0, 1, 0,  0, 0, 0, 2'd0, 0, 0, 1, 5'd0, 0);
        add(0, 0, 0, 1,  0, 0, 0, 2'd0, 0, 0, 0, 5'd0, 0);
        add(0, 0, 0, 0,  1, 0, 0, 2'd0, 0, 0, 0, 5'd0, 0);
        // Stalled load, two updates, winner on the third SUM.
        add(1, 0, 0, 0,  1, 0, 0, 2'd0, 0, 0, 0, 5'd0, 0);
        add(0, 0, 1, 0,  0, 1, 1, 2'd0, 0, 0, 0, 5'd0, 0);
        add(0, 0, 0, 0,  0, 1, 0, 2'd1, 0, 0, 0, 5'd0, 0);
        add(0, 0, 1, 0,  0, 1, 1, 2'd1, 0, 0, 0, 5'd0, 0);
        add(0, 0, 0, 0,  0, 1, 0, 2'd2, 0, 0, 0, 5'd0, 0);
        add(0, 0, 1, 0,  0, 1, 1, 2'd2, 0, 0, 0, 5'd0, 0);
        add(0, 0, 0, 0,  0, 1, 0, 2'd3, 0, 0, 0, 5'd0, 0);
        add(0, 0, 1, 0,  0, 1, 1, 2'd3, 0, 0, 0, 5'd0, 0);
        add(0, 0, 0, 0,  0, 0, 0, 2'd0, 1, 1, 0, 5'd0, 0);
        add(0, 0, 0, 0,  0, 0, 0, 2'd0, 0, 0, 1, 5'd0, 0);
        add(0, 0, 0, 0,  0, 0, 0, 2'd0, 0, 0, 0, 5'd0, 0);
        add(0, 0, 0, 0,  0, 0, 0, 2'd0, 1, 0, 0, 5'd0, 0);
        add(0, 0, 0, 0,  0, 0, 0, 2'd0, 0, 0, 1, 5'd1, 0);
        add(0, 0, 0, 0,  0, 0, 0, 2'd0, 0, 0, 0, 5'd1, 0);
        add(0, 0, 0, 0,  0, 0, 0, 2'd0, 1, 0, 0, 5'd1, 0);
        add(0, 0, 0, 0,  0, 0, 0, 2'd0, 0, 0, 1, 5'd2, 0);
        add(0, 0, 0, 1,  0, 0, 0, 2'd0, 0, 0, 0, 5'd2, 0);
        add(0, 0, 0, 0,  1, 0, 0, 2'd0, 0, 0, 0, 5'd2, 0);
        // Abort on the second LOAD cycle.
        add(1, 0, 1, 0,  1, 0, 0, 2'd0, 0, 0, 0, 5'd2, 0);
        add(0, 0, 1, 0,  0, 1, 1, 2'd0, 0, 0, 0, 5'd0, 0);
        add(0, 1, 1, 0,  0, 1, 0, 2'd1, 0, 0, 0, 5'd0, 0);
        add(0, 0, 1, 0,  1, 0, 0, 2'd0, 0, 0, 0, 5'd0, 0);
        add(0, 0, 1, 0,  1, 0, 0, 2'd0, 0, 0, 0, 5'd0, 0);
        // Abort in INIT suppresses ld_reg.
        add(1, 0, 1, 0,  1, 0, 0, 2'd0, 0, 0, 0, 5'd0, 0);
        add(0, 0, 1, 0,  0, 1, 1, 2'd0, 0, 0, 0, 5'd0, 0);
        add(0, 0, 1, 0,  0, 1, 1, 2'd1, 0, 0, 0, 5'd0, 0);
        add(0, 0, 1, 0,  0, 1, 1, 2'd2, 0, 0, 0, 5'd0, 0);
        add(0, 0, 1, 0,  0, 1, 1, 2'd3, 0, 0, 0, 5'd0, 0);
        add(0, 1, 0, 0,  0, 0, 0, 2'd0, 0, 1, 0, 5'd0, 0);
        add(0, 0, 0, 0,  1, 0, 0, 2'd0, 0, 0, 0, 5'd0, 0);

        // Reset with start and in_valid held high.
        rst = 1'b1; start_a = 1'b1; start_b = 1'b1; abort = 1'b0; in_valid = 1'b1; finish = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_a", 32'(a_out), 32'(15'h4000));
        check("reset_b", 32'(b_out), 32'(15'h4000));
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            start_a  = vecs[i].start;
            abort    = vecs[i].abort;
            in_valid = vecs[i].in_valid;
            finish   = vecs[i].finish;
            #1;
            exp = {vecs[i].done, ~vecs[i].done, vecs[i].rdy, vecs[i].ldm, vecs[i].addr,
                   vecs[i].ldr, vecs[i].sel, vecs[i].mul, vecs[i].to, vecs[i].iter};
            check($sformatf("vec%0d", i), 32'(a_out), 32'(exp));
        end

        // MUL_LAT=3, MAX_ITER=2, finish held low: runs into the iteration cap.
        @(negedge clk);
        start_a = 1'b0; abort = 1'b0; finish = 1'b0; in_valid = 1'b0; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0; in_valid = 1'b1;
        cyc = 1; run = 0; runs = 0; bad_run = 0; upd = 0;
        while (!b_done && cyc < 100) begin
            #1;
            if (b_mul_en) begin
                run++;
            end else if (run != 0) begin
                runs++;
                if (run != 3) bad_run++;
                run = 0;
            end
            if (b_ld_reg && !b_sel) upd++;
            @(negedge clk);
            cyc++;
        end
        #1;
        check("to_latency", 32'(cyc), 32'd20);
        check("to_mul_runs", 32'(runs), 32'd3);
        check("to_mul_bad_len", 32'(bad_run), 32'd0);
        check("to_updates", 32'(upd), 32'd2);
        check("to_timeout", 32'(b_timeout), 32'd1);
        check("to_iter", 32'(b_iter), 32'd2);

        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("to_sticky", 32'(b_timeout), 32'd1);

        // A new start clears the flag; then abort in LOAD.
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0; in_valid = 1'b1; abort = 1'b1;
        #1;
        check("restart_timeout", 32'(b_timeout), 32'd0);
        check("restart_ready", 32'(b_in_ready), 32'd1);
        check("abort_ldm", 32'(b_ld_memory), 32'd0);
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("abort_done", 32'(b_done), 32'd1);
        check("abort_iter", 32'(b_iter), 32'd0);
        check("abort_timeout", 32'(b_timeout), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/maxnet_ctrl_param.md
Name: maxnet_ctrl_param

Overview:
- Parametrised control unit for the MaxNet datapath: accepts N input activations over a valid/ready handshake, then runs Init → (Mul → Sum → Update)* until the datapath reports a single winner.
- Generalises the fixed controller with four additions: configurable neuron count, multi-cycle multiplier latency, an iteration cap with timeout flag, and a synchronous abort.
- Sits between the top-level start/abort interface and the MaxNet register/memory datapath.

Parameters:
- N, 4, number of neurons / input words loaded per run (≥1).
- ADDR_W, 2, width of load address; must satisfy 2^ADDR_W ≥ N.
- MUL_LAT, 1, cycles the multiplier needs; the controller stays in MUL this many cycles (≥1).
- MAX_ITER, 16, maximum number of Update passes before timeout (≥1).
- ITER_W, 5, width of iter_count; must hold MAX_ITER.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- abort  input  1  return to IDLE next cycle from any non-IDLE state.
- in_valid  input  1  input word present on the datapath bus.
- in_ready  output  1  controller accepts an input word this cycle.
- finish  input  1  datapath: exactly one nonzero activation remains; sampled in SUM.
- ld_memory  output  1  write current input word to memory[ld_addr].
- ld_addr  output  ADDR_W  memory write address during LOAD.
- ld_reg  output  1  load activation registers.
- sel  output  1  1 = register input from memory (init), 0 = from adder (update).
- mul_en  output  1  multiplier operand enable; high throughout MUL.
- done  output  1  high while in IDLE.
- busy  output  1  inverse of done.
- iter_count  output  ITER_W  number of Update passes in the current or last run.
- timeout  output  1  last run ended on the iteration cap; sticky until the next accepted start.

Behaviour:
- States: IDLE, LOAD, INIT, MUL, SUM, UPDATE. Moore outputs, with two exceptions: ld_memory and in_ready are also gated combinationally by in_valid/state as stated below.
- Reset (synchronous, rst=1 at clk edge): state=IDLE, ld_cnt=0, mul_cnt=0, iter_count=0, timeout=0. Outputs after reset: done=1, busy=0; ld_memory, ld_reg, sel, mul_en, in_ready all 0; ld_addr=0. rst overrides every other input.
- IDLE: done=1. On start=1 go to LOAD, clear ld_cnt, iter_count and timeout.
- LOAD: in_ready=1; ld_memory = in_valid; ld_addr = ld_cnt.
  - An input word is accepted only when in_valid=1, which increments ld_cnt.
  - On the acceptance where ld_cnt==N-1, go to INIT. Otherwise stay in LOAD.
  - in_valid=0 stalls indefinitely without timeout.
- INIT: ld_reg=1, sel=1, one cycle, then MUL with mul_cnt=0.
- MUL: mul_en=1. mul_cnt increments each cycle. When mul_cnt==MUL_LAT-1, go to SUM. Dwell is exactly MUL_LAT cycles.
- SUM: one cycle; finish is sampled here.
  - finish=1 → IDLE, timeout=0.
  - finish=0 and iter_count==MAX_ITER → IDLE, timeout=1.
  - Otherwise → UPDATE.
- UPDATE: ld_reg=1, sel=0, iter_count+1, then MUL with mul_cnt=0.
- Latency with no stalls: start-high cycle → IDLE re-entered after 1 + N + 1 + k·(MUL_LAT+2) + MUL_LAT + 1 cycles, where k = number of Update passes (k ≤ MAX_ITER).
- abort=1 in any non-IDLE state → IDLE next edge. Any pending ld_memory/ld_reg of that cycle is suppressed. iter_count is held, timeout stays 0. abort has priority over every other transition except rst.
- start during a non-IDLE state is ignored. start and abort both high in IDLE: start wins, since abort only acts outside IDLE.
- finish outside SUM is ignored.
- The controller never drives ld_memory and ld_reg in the same cycle.
- Illegal state encodings → IDLE on the next edge.

Test Plan:
- Reset check: rst=1 for 2 cycles, with start=1 and in_valid=1 held → done=1, busy=0, all load strobes 0, iter_count=0, timeout=0.
- Nominal run (N=4, MUL_LAT=1): start pulse, then in_valid held high → ld_memory high 4 cycles with ld_addr 0,1,2,3. INIT asserts ld_reg=1, sel=1 for 1 cycle. finish=1 at the first SUM → done rises 8 cycles after the start cycle, iter_count=0.
- Stalled load plus iterations: in_valid toggles 1,0,1,0,… → ld_addr advances only on valid cycles. finish=1 at the third SUM → iter_count=2, and ld_reg with sel=0 seen exactly twice.
- Multiplier latency: MUL_LAT=3 → mul_en high exactly 3 consecutive cycles before each SUM.
- Timeout (MAX_ITER=2): finish held 0 → exactly 2 UPDATE cycles, then IDLE with timeout=1, iter_count=2. A following start clears timeout.
- Abort and ignored start: abort=1 during the 2nd LOAD cycle → IDLE next cycle, no further ld_memory, timeout=0. start asserted mid-run in MUL → no state change.
